hls_deadlock_axis_monitor: RTL and testbench

// - Parametrised deadlock monitor for one HLS dataflow region: watches NUM_AXIS AXI-Stream

---
 rtl/hls_deadlock_pkg.sv | 23 ++
 rtl/hls_deadlock_chan_timer.sv | 44 ++++
 rtl/hls_deadlock_axis_monitor.sv | 122 ++++++++++++
 tb/tb_hls_deadlock_axis_monitor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hls_deadlock_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock monitor.
// Contents: monitor state enum (IDLE, SUSPECT, BLOCKED) and first_set_idx().
// Latency: n/a (declarations only). Backpressure: n/a.
package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSPECT = 2'd1,
    BLOCKED = 2'd2
  } mon_state_t;

  // Index+1 of the lowest set bit of mask, 0 when mask is empty.
  // Scanning from the top down lets the lowest set bit overwrite last.
  function automatic logic [5:0] first_set_idx(input logic [31:0] mask);
    logic [5:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i]) idx = 6'(i + 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hls_deadlock_chan_timer.sv
// Persistence timer for one AXIS channel: counts consecutive stalled cycles.
// Latency: confirmed is 1 cycle after the THRESHOLD-th stalled cycle; confirm_next is
// combinational. Backpressure: none, purely observes block_sig.
// Ports: clock, reset (sync, active-high), clear (sync rearm), block_sig (channel stalled),
//        confirmed (registered timer == THRESHOLD), confirm_next (timer reaches THRESHOLD
//        at the coming edge).
module hls_deadlock_chan_timer #(
  parameter int THRESHOLD = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic block_sig,
  output logic confirmed,
  output logic confirm_next
);

  localparam int TW = $clog2(THRESHOLD + 1);
  localparam logic [TW-1:0] TH = TW'(THRESHOLD);

  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;

  // Any cycle without a stall restarts the count from zero.
  always_comb begin
    timer_nxt = '0;
    if (block_sig) begin
      timer_nxt = (timer == TH) ? TH : timer + TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      timer <= '0;
    end else begin
      timer <= timer_nxt;
    end
  end

  assign confirmed    = (timer == TH);
  // Lets the monitor commit to BLOCKED on the same edge the timer saturates.
  assign confirm_next = (timer_nxt == TH);

endmodule

// File: rtl/hls_deadlock_axis_monitor.sv
// Deadlock monitor for one HLS dataflow region: flags AXIS / sub-instance stalls that persist.
// Latency: stall held from cycle t -> block at the edge after cycle t+THRESHOLD-1.
// Backpressure: none, observe-only; block feeds the parent monitor.
// Ports: clock, reset (sync, active-high, wins over clear), axis_block_sigs[NUM_AXIS],
//        inst_idle_sigs[NUM_INST], inst_block_sigs[NUM_INST], clear (rearm, keeps event_cnt),
//        axis_block_info (confirmed mask while blocked), first_idx (lowest confirmed ch + 1),
//        block (registered deadlock flag), event_cnt (saturating BLOCKED-entry count).
// Config macro: HLS_DEADLOCK_STICKY_EN -> BLOCKED left only via clear/reset, info ORs up.
module hls_deadlock_axis_monitor
  import hls_deadlock_pkg::*;
#(
  parameter int NUM_AXIS  = 1,
  parameter int NUM_INST  = 2,
  parameter int THRESHOLD = 1,
  parameter int CNT_W     = 16,
  localparam int FI_W     = $clog2(NUM_AXIS + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic                clear,
  output logic [NUM_AXIS-1:0] axis_block_info,
  output logic [FI_W-1:0]     first_idx,
  output logic                block,
  output logic [CNT_W-1:0]    event_cnt
);

  logic [NUM_AXIS-1:0] confirmed;
  logic [NUM_AXIS-1:0] hit;
  mon_state_t          state;
  mon_state_t          state_nxt;
  logic                cond;
  logic                enter;

  for (genvar i = 0; i < NUM_AXIS; i++) begin : g_chan
    hls_deadlock_chan_timer #(
      .THRESHOLD(THRESHOLD)
    ) u_timer (
      .clock       (clock),
      .reset       (reset),
      .clear       (clear),
      .block_sig   (axis_block_sigs[i]),
      .confirmed   (confirmed[i]),
      .confirm_next(hit[i])
    );
  end

  // All instances idle means the region has finished, so nothing counts as a deadlock.
  assign cond = ((|hit) || (|inst_block_sigs)) && !(&inst_idle_sigs);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cond) state_nxt = BLOCKED;
        else if (|axis_block_sigs) state_nxt = SUSPECT;
      end
      SUSPECT: begin
        if (cond) state_nxt = BLOCKED;
        else if (!(|axis_block_sigs)) state_nxt = IDLE;
      end
      BLOCKED: begin
`ifdef HLS_DEADLOCK_STICKY_EN
        state_nxt = BLOCKED;
`else
        if (!cond) state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enter = (state != BLOCKED) && (state_nxt == BLOCKED);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      first_idx <= '0;
    end else if (enter) begin
      first_idx <= FI_W'(first_set_idx(32'(hit)));
    end else if (state_nxt != BLOCKED) begin
      first_idx <= '0;
    end
  end

  // clear suppresses the increment of a simultaneous entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      event_cnt <= '0;
    end else if (enter && !clear && (event_cnt != {CNT_W{1'b1}})) begin
      event_cnt <= event_cnt + CNT_W'(1);
    end
  end

  assign block = (state == BLOCKED);

`ifdef HLS_DEADLOCK_STICKY_EN
  logic [NUM_AXIS-1:0] info_acc;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      info_acc <= '0;
    end else begin
      info_acc <= axis_block_info;
    end
  end

  assign axis_block_info = block ? (info_acc | confirmed) : '0;
`else
  assign axis_block_info = block ? confirmed : '0;
`endif

endmodule

// File: tb/tb_hls_deadlock_axis_monitor.sv
// Bench for hls_deadlock_axis_monitor: directed scenarios then random traffic,
// every cycle compared against a run-length based reference model.
module tb_hls_deadlock_axis_monitor;

  localparam int NA   = 4;
  localparam int NI   = 2;
  localparam int TH   = 4;
  localparam int CW   = 4;
  localparam int FW   = $clog2(NA + 1);
  localparam int CMAX = (1 << CW) - 1;
`ifdef HLS_DEADLOCK_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [NA-1:0] axis_block_sigs;
  logic [NI-1:0] inst_idle_sigs;
  logic [NI-1:0] inst_block_sigs;
  logic          clear;
  logic [NA-1:0] axis_block_info;
  logic [FW-1:0] first_idx;
  logic          block;
  logic [CW-1:0] event_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: consecutive-stall run length per channel plus observable outputs.
  int            run [NA];
  bit            m_blk;
  logic [NA-1:0] m_info;
  int            m_fi;
  int            m_cnt;

  hls_deadlock_axis_monitor #(
    .NUM_AXIS (NA),
    .NUM_INST (NI),
    .THRESHOLD(TH),
    .CNT_W    (CW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs (inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs),
    .clear          (clear),
    .axis_block_info(axis_block_info),
    .first_idx      (first_idx),
    .block          (block),
    .event_cnt      (event_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the current inputs, clock the DUT, compare.
  task automatic step(input string tag);
    logic [NA-1:0] hitm;
    bit            cond;
    bit            nb;
    hitm = '0;
    for (int i = 0; i < NA; i++) begin
      if (axis_block_sigs[i] && (run[i] + 1 >= TH)) hitm[i] = 1'b1;
    end
    cond = ((|hitm) || (|inst_block_sigs)) && !(&inst_idle_sigs);
    if (reset || clear) begin
      m_blk  = 1'b0;
      m_info = '0;
      m_fi   = 0;
      if (reset) m_cnt = 0;
      for (int i = 0; i < NA; i++) run[i] = 0;
    end else begin
      nb = m_blk ? (STICKY ? 1'b1 : cond) : cond;
      if (nb && !m_blk) begin
        m_fi = 0;
        for (int i = NA - 1; i >= 0; i--) if (hitm[i]) m_fi = i + 1;
        if (m_cnt < CMAX) m_cnt++;
        m_info = hitm;
      end else if (nb) begin
        m_info = STICKY ? (m_info | hitm) : hitm;
      end else begin
        m_info = '0;
        m_fi   = 0;
      end
      m_blk = nb;
      for (int i = 0; i < NA; i++) begin
        run[i] = axis_block_sigs[i] ? ((run[i] < TH) ? run[i] + 1 : TH) : 0;
      end
    end
    @(posedge clock);
    #1;
    check({tag, ".block"}, 32'(block), 32'(m_blk));
    check({tag, ".info"}, 32'(axis_block_info), 32'(m_info));
    check({tag, ".first_idx"}, 32'(first_idx), 32'(m_fi));
    check({tag, ".event_cnt"}, 32'(event_cnt), 32'(m_cnt));
  endtask

  task automatic pulse_clear(input string tag);
    clear = 1'b1;
    step(tag);
    clear = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NA; i++) run[i] = 0;
    m_blk = 1'b0; m_info = '0; m_fi = 0; m_cnt = 0;
    reset = 1'b1; clear = 1'b0;
    axis_block_sigs = '0; inst_idle_sigs = '0; inst_block_sigs = '0;
    step("reset0");
    step("reset1");
    check("reset_block", 32'(block), 32'd0);
    check("reset_cnt", 32'(event_cnt), 32'd0);
    reset = 1'b0;
    step("idle");

    // ch2: 3-cycle burst, gap, 4-cycle burst.
    axis_block_sigs = 4'b0100;
    for (int k = 0; k < 3; k++) step("thr_burst1");
    check("thr_burst1_block", 32'(block), 32'd0);
    axis_block_sigs = 4'b0000;
    step("thr_gap");
    axis_block_sigs = 4'b0100;
    for (int k = 0; k < 3; k++) step("thr_burst2");
    check("thr_burst2_pre", 32'(block), 32'd0);
    step("thr_burst2_4th");
    check("thr_block", 32'(block), 32'd1);
    check("thr_first_idx", 32'(first_idx), 32'd3);
    check("thr_info", 32'(axis_block_info), 32'h4);
    check("thr_cnt", 32'(event_cnt), 32'd1);
    axis_block_sigs = 4'b0000;
    step("release");
    check("release_block", 32'(block), STICKY ? 32'd1 : 32'd0);
    step("release2");
    pulse_clear("release_clear");
    check("after_clear_block", 32'(block), 32'd0);

    // Sub-instance deadlock with no AXIS stall.
    inst_block_sigs = 2'b01;
    step("inst_blk");
    check("inst_block", 32'(block), 32'd1);
    check("inst_first_idx", 32'(first_idx), 32'd0);
    check("inst_info", 32'(axis_block_info), 32'd0);
    inst_block_sigs = 2'b00;
    step("inst_rel");
    pulse_clear("inst_clear");

    // All instances idle suppresses detection even with ch0 confirmed.
    inst_idle_sigs  = 2'b11;
    axis_block_sigs = 4'b0001;
    for (int k = 0; k < 6; k++) step("idle_suppress");
    check("idle_suppress_block", 32'(block), 32'd0);
    inst_idle_sigs = 2'b00;
    step("idle_lift");
    check("idle_lift_block", 32'(block), 32'd1);
    check("idle_lift_first_idx", 32'(first_idx), 32'd1);
    axis_block_sigs = 4'b0000;
    step("idle_rel");
    pulse_clear("idle_clear");
    check("cnt_before_clr_entry", 32'(event_cnt), 32'd3);

    // clear coinciding with an entry wins and does not count.
    inst_block_sigs = 2'b01;
    clear = 1'b1;
    step("clr_entry");
    clear = 1'b0;
    inst_block_sigs = 2'b00;
    check("clr_entry_block", 32'(block), 32'd0);
    check("clr_entry_cnt", 32'(event_cnt), 32'd3);

    // Drive the counter into saturation.
    for (int k = 0; k < 16; k++) begin
      inst_block_sigs = 2'b01;
      step("sat_enter");
      inst_block_sigs = 2'b00;
      pulse_clear("sat_clear");
    end
    check("sat_cnt", 32'(event_cnt), 32'hF);

    // reset and clear together mid-BLOCKED: reset wins, counter zeroed.
    axis_block_sigs = 4'b1010;
    for (int k = 0; k < 5; k++) step("pre_rst");
    check("pre_rst_block", 32'(block), 32'd1);
    check("pre_rst_first_idx", 32'(first_idx), 32'd2);
    reset = 1'b1; clear = 1'b1;
    step("rst_clr");
    reset = 1'b0; clear = 1'b0;
    check("rst_clr_block", 32'(block), 32'd0);
    check("rst_clr_info", 32'(axis_block_info), 32'd0);
    check("rst_clr_cnt", 32'(event_cnt), 32'd0);
    axis_block_sigs = '0;
    step("post_rst");

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < NA; i++) axis_block_sigs[i] = ($urandom_range(3) != 0);
      inst_block_sigs = ($urandom_range(15) == 0) ? NI'($urandom_range(1, 3)) : '0;
      inst_idle_sigs  = ($urandom_range(7) == 0) ? '1 : NI'($urandom_range(2));
      clear           = ($urandom_range(31) == 0);
      reset           = ($urandom_range(199) == 0);
      step("rand");
    end
    reset = 1'b0; clear = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
